// File: rtl/simplerisc_pkg.sv
// Shared SimpleRISC pipeline constants, fetch FSM state type and PC helper.
package simplerisc_pkg;

  localparam logic [31:0] RESET_PC  = 32'h0000_0000;
  localparam logic [31:0] PC_STEP   = 32'h0000_0004;
  localparam logic [31:0] NOP_INSTR = 32'h6800_0000;

  typedef enum logic [0:0] {
    BOOT  = 1'b0,
    FETCH = 1'b1
  } fetch_state_t;

  // Modulo-2^32 PC advance; wrap from the top of memory is intentional.
  function automatic logic [31:0] pc_advance(input logic [31:0] pc, input logic [31:0] step);
    return pc + step;
  endfunction

endpackage

// File: rtl/if_of_reg.sv
// Generic pipeline latch {pc, instruction, valid} with flush > hold > load priority;
// an idle cycle (no flush, hold or load) inserts a bubble.
module if_of_reg
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        hold,
  input  logic        load,
  input  logic [31:0] load_pc,
  input  logic [31:0] load_instr,
  input  logic        load_valid,
  output logic [31:0] pc,
  output logic [31:0] instruction,
  output logic        valid
);

  // Latch update: reset and flush both produce the bubble encoding.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= 32'h0000_0000;
      instruction <= BUBBLE_INSTR;
      valid       <= 1'b0;
    end else if (flush) begin
      pc          <= 32'h0000_0000;
      instruction <= BUBBLE_INSTR;
      valid       <= 1'b0;
    end else if (hold) begin
      pc          <= pc;
      instruction <= instruction;
      valid       <= valid;
    end else if (load) begin
      pc          <= load_pc;
      instruction <= load_instr;
      valid       <= load_valid;
    end else begin
      pc          <= 32'h0000_0000;
      instruction <= BUBBLE_INSTR;
      valid       <= 1'b0;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// SimpleRISC instruction fetch: PC, BOOT/FETCH FSM, imem handshake and IF/OF latch.
// Optional one-entry skid buffer for fetches completing under stall: IF_SKID_BUF_EN.
module fetch_stage
  import simplerisc_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = simplerisc_pkg::RESET_PC,
  parameter logic [31:0] PC_STEP   = simplerisc_pkg::PC_STEP,
  parameter logic [31:0] NOP_INSTR = simplerisc_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] of_pc,
  output logic [31:0] of_instruction,
  output logic        of_valid
);

  fetch_state_t state_r;
  logic [31:0]  pc_r;
  logic         imem_req_r;

  logic         latch_flush_s;
  logic         latch_hold_s;
  logic         latch_load_s;
  logic [31:0]  latch_pc_s;
  logic [31:0]  latch_instr_s;

`ifdef IF_SKID_BUF_EN
  logic         skid_valid_r;
  logic [31:0]  skid_pc_r;
  logic [31:0]  skid_instr_r;
`endif

  assign imem_addr = pc_r;
  assign imem_req  = imem_req_r;

  // IF/OF latch control: branch flush beats stall hold beats fetch completion.
  always_comb begin
    latch_flush_s = 1'b0;
    latch_hold_s  = 1'b0;
    latch_load_s  = 1'b0;
    latch_pc_s    = pc_r;
    latch_instr_s = imem_rdata;
    case (state_r)
      BOOT: begin
        latch_flush_s = 1'b1;
      end
      FETCH: begin
        if (branch_taken) begin
          latch_flush_s = 1'b1;
        end else if (stall) begin
          latch_hold_s = 1'b1;
`ifdef IF_SKID_BUF_EN
        end else if (skid_valid_r) begin
          latch_load_s  = 1'b1;
          latch_pc_s    = skid_pc_r;
          latch_instr_s = skid_instr_r;
`endif
        end else if (imem_ready) begin
          latch_load_s = 1'b1;
        end else begin
          latch_flush_s = 1'b1;
        end
      end
      default: begin
        latch_flush_s = 1'b1;
      end
    endcase
  end

  // PC, FSM, request and skid buffer; rst overrides any in-flight response.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= BOOT;
      pc_r         <= RESET_PC;
      imem_req_r   <= 1'b0;
`ifdef IF_SKID_BUF_EN
      skid_valid_r <= 1'b0;
      skid_pc_r    <= 32'h0000_0000;
      skid_instr_r <= NOP_INSTR;
`endif
    end else begin
      case (state_r)
        BOOT: begin
          state_r    <= FETCH;
          imem_req_r <= 1'b1;
        end
        FETCH: begin
          if (branch_taken) begin
            pc_r         <= branch_target;
            imem_req_r   <= 1'b1;
`ifdef IF_SKID_BUF_EN
            skid_valid_r <= 1'b0;
`endif
          end else if (stall) begin
`ifdef IF_SKID_BUF_EN
            // Park a fetch that lands during stall so it need not be refetched.
            if (!skid_valid_r && imem_ready) begin
              skid_valid_r <= 1'b1;
              skid_pc_r    <= pc_r;
              skid_instr_r <= imem_rdata;
              pc_r         <= pc_advance(pc_r, PC_STEP);
              imem_req_r   <= 1'b0;
            end else begin
              pc_r <= pc_r;
            end
`else
            pc_r <= pc_r;
`endif
`ifdef IF_SKID_BUF_EN
          end else if (skid_valid_r) begin
            skid_valid_r <= 1'b0;
            imem_req_r   <= 1'b1;
`endif
          end else if (imem_ready) begin
            pc_r <= pc_advance(pc_r, PC_STEP);
          end else begin
            pc_r <= pc_r;
          end
        end
        default: begin
          state_r    <= BOOT;
          imem_req_r <= 1'b0;
        end
      endcase
    end
  end

  if_of_reg #(
    .BUBBLE_INSTR (NOP_INSTR)
  ) u_if_of_reg (
    .clk         (clk),
    .rst         (rst),
    .flush       (latch_flush_s),
    .hold        (latch_hold_s),
    .load        (latch_load_s),
    .load_pc     (latch_pc_s),
    .load_instr  (latch_instr_s),
    .load_valid  (1'b1),
    .pc          (of_pc),
    .instruction (of_instruction),
    .valid       (of_valid)
  );

endmodule
